// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: raster timing bundle between the timing generator and its consumers
//   master : timing generator (drives position, sync, enables and strobes; samples EN)
//   slave  : pixel pipeline / output encoder (drives EN; samples everything else)
//   FRAME_CNT exists only when VTG_FRAME_CNT_EN is defined
interface video_timing_gen_if #(parameter int CW = 12) ();
  logic          EN;
  logic [CW-1:0] SX;
  logic [CW-1:0] SY;
  logic          HSYNC;
  logic          VSYNC;
  logic          DE;
  logic          VBLANK;
  logic          LINE_START;
  logic          FRAME_START;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0]   FRAME_CNT;
  modport master (input EN, output SX, SY, HSYNC, VSYNC, DE, VBLANK, LINE_START, FRAME_START, FRAME_CNT);
  modport slave  (output EN, input SX, SY, HSYNC, VSYNC, DE, VBLANK, LINE_START, FRAME_START, FRAME_CNT);
`else
  modport master (input EN, output SX, SY, HSYNC, VSYNC, DE, VBLANK, LINE_START, FRAME_START);
  modport slave  (output EN, input SX, SY, HSYNC, VSYNC, DE, VBLANK, LINE_START, FRAME_START);
`endif
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised progressive raster timing generator with registered, zero-skew outputs
//   PCLK        : pixel clock
//   RST_PCLK_N  : asynchronous active-low reset, released synchronously to PCLK
//   vif.EN      : advance enable, low stalls the raster and suppresses strobes
//   vif.SX/SY   : current pixel position
//   vif.HSYNC/VSYNC, DE, VBLANK, LINE_START, FRAME_START : timing describing SX/SY of the same cycle
//   Optional macro VTG_FRAME_CNT_EN adds vif.FRAME_CNT, a 16-bit wrapping frame counter
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 12
) (
  input logic               PCLK,
  input logic               RST_PCLK_N,
  video_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  logic [CW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic          de_q, de_d, vblank_q, vblank_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic          line_q, line_d, frame_q, frame_d, sx_wrap;
  // Every output register is loaded from the next position, so outputs and SX/SY stay aligned.
  // On a stall the next position equals the current one, which holds all levels automatically.
  always_comb begin
    sx_wrap  = sx_q == H_LAST;
    sx_d     = !vif.EN ? sx_q : sx_wrap ? '0 : sx_q + 1'b1;
    sy_d     = !(vif.EN && sx_wrap) ? sy_q : (sy_q == V_LAST) ? '0 : sy_q + 1'b1;
    de_d     = (sx_d < H_ACT) && (sy_d < V_ACT);
    vblank_d = sy_d >= V_ACT;
    hsync_d  = (sx_d >= HS_BEG && sx_d < HS_END) ? H_POL : ~H_POL;
    vsync_d  = (sy_d >= VS_BEG && sy_d < VS_END) ? V_POL : ~V_POL;
    line_d   = vif.EN && (sx_d == '0);
    frame_d  = line_d && (sy_d == '0);
  end
  always_ff @(posedge PCLK or negedge RST_PCLK_N) begin
    if (!RST_PCLK_N) begin
      sx_q     <= H_LAST;
      sy_q     <= V_LAST;
      de_q     <= 1'b0;
      vblank_q <= 1'b1;
      hsync_q  <= ~H_POL;
      vsync_q  <= ~V_POL;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      de_q     <= de_d;
      vblank_q <= vblank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
    end
  end
  assign vif.SX          = sx_q;
  assign vif.SY          = sy_q;
  assign vif.DE          = de_q;
  assign vif.VBLANK      = vblank_q;
  assign vif.HSYNC       = hsync_q;
  assign vif.VSYNC       = vsync_q;
  assign vif.LINE_START  = line_q;
  assign vif.FRAME_START = frame_q;
`ifdef VTG_FRAME_CNT_EN
  // Counts in the same edge that raises FRAME_START, so the first frame reads 1.
  logic [15:0] fcnt_q, fcnt_d;
  always_comb fcnt_d = fcnt_q + 16'(frame_d);
  always_ff @(posedge PCLK or negedge RST_PCLK_N) begin
    if (!RST_PCLK_N) fcnt_q <= '0;
    else fcnt_q <= fcnt_d;
  end
  assign vif.FRAME_CNT = fcnt_q;
`endif
endmodule
